// File: rtl/wb_write_port_pkg.sv
// ----------------------------------------------------------------------------
// wb_write_port_pkg
// Shared definitions for the write-back writer: reset and write-enable
// levels, null register address, zero word, default bus types and the
// stall-vector bit positions used by the stall controller.
// ----------------------------------------------------------------------------
package wb_write_port_pkg;

   localparam logic RstEnable    = 1'b1;
   localparam logic RstDisable   = 1'b0;
   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;

   localparam logic [4:0]  NOPRegAddr = 5'd0;
   localparam logic [31:0] ZeroWord   = 32'd0;

   typedef logic [31:0] RegBus;
   typedef logic [4:0]  RegAddrBus;

   // Stall vector bit positions: bit4 = MEM stalled, bit5 = WB stalled.
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

endpackage

// File: rtl/wb_result_fifo.sv
// ----------------------------------------------------------------------------
// wb_result_fifo
// Parameterised synchronous FIFO holding late divider results until a free
// slot on the register-file write port appears.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   i_push     write i_din (ignored while full)
//   i_din      entry to write
//   i_pop      drop the head entry (ignored while empty)
//   o_dout     head entry (valid while !o_empty)
//   o_full     count == DEPTH
//   o_empty    count == 0
//   o_count    number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module wb_result_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 37
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [W-1:0]               i_din,
   input  logic                       i_pop,
   output logic [W-1:0]               o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;

   logic w_push;
   logic w_pop;

   // Guard the handshakes locally so the FIFO can never over/underflow.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop  && !o_empty;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_din;
      end
   end

   // DEPTH is a power of two, so pointer wrap is the natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wb_write_port.sv
// ----------------------------------------------------------------------------
// wb_write_port
// Write-back stage writer. Registers MEM-stage results into the WB stage
// register and drives the register file's single write port (which doubles
// as the WB forwarding source). Late divider results wait in a small FIFO
// and are written in cycles where the stage register holds no write.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall_i[5:0]    stall vector (bit4 MEM stalled, bit5 WB stalled)
//   flush_i         squash the WB stage register (queue is kept)
//   mem_*_i         MEM-stage write enable / destination / result
//   div_valid_i     divider result valid, accepted when div_ready_o
//   div_ready_o     queue not full (registered count only)
//   div_waddr_i     divider destination
//   div_wdata_i     divider result
//   wb_wreg_o       regfile write enable / WB forwarding enable
//   wb_waddr_o      regfile write address
//   wb_wdata_o      regfile write data
//   stall_req_o     queue full: ask the stall controller for a bubble
//
// Optional feature (macro HILO_WB_EN): adds mem_whilo_i/mem_hi_i/mem_lo_i
// inputs and wb_whilo_o/wb_hi_o/wb_lo_o outputs carried by the stage
// register. HI/LO is never sourced from the divider queue.
// ----------------------------------------------------------------------------
module wb_write_port
   import wb_write_port_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int REG_W      = 32,
   parameter int QDEPTH     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            stall_i,
   input  logic                  flush_i,
   input  logic                  mem_wreg_i,
   input  logic [REG_ADDR_W-1:0] mem_waddr_i,
   input  logic [REG_W-1:0]      mem_wdata_i,
   input  logic                  div_valid_i,
   output logic                  div_ready_o,
   input  logic [REG_ADDR_W-1:0] div_waddr_i,
   input  logic [REG_W-1:0]      div_wdata_i,
   output logic                  wb_wreg_o,
   output logic [REG_ADDR_W-1:0] wb_waddr_o,
   output logic [REG_W-1:0]      wb_wdata_o,
`ifdef HILO_WB_EN
   input  logic                  mem_whilo_i,
   input  logic [REG_W-1:0]      mem_hi_i,
   input  logic [REG_W-1:0]      mem_lo_i,
   output logic                  wb_whilo_o,
   output logic [REG_W-1:0]      wb_hi_o,
   output logic [REG_W-1:0]      wb_lo_o,
`endif
   output logic                  stall_req_o
);

   localparam int QW    = REG_ADDR_W + REG_W;
   localparam int CNT_W = $clog2(QDEPTH) + 1;
   localparam logic [CNT_W-1:0] QFULL_CNT = CNT_W'(QDEPTH);

   // WB stage register
   logic                  r_wreg;
   logic [REG_ADDR_W-1:0] r_waddr;
   logic [REG_W-1:0]      r_wdata;
`ifdef HILO_WB_EN
   logic                  r_whilo;
   logic [REG_W-1:0]      r_hi;
   logic [REG_W-1:0]      r_lo;
`endif

   logic             w_push;
   logic             w_pop;
   logic [QW-1:0]    w_q_head;
   logic             w_q_full;
   logic             w_q_empty;
   logic [CNT_W-1:0] w_q_count;
   logic             w_mem_stall;
   logic             w_wb_stall;
   logic             w_unused;

   assign w_mem_stall = stall_i[STALL_MEM];
   assign w_wb_stall  = stall_i[STALL_WB];
   assign w_unused    = &{1'b0, stall_i[3:0]};

   // ---- MEM -> WB stage boundary ----
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_wreg  <= WriteDisable;
         r_waddr <= '0;
         r_wdata <= '0;
`ifdef HILO_WB_EN
         r_whilo <= WriteDisable;
         r_hi    <= '0;
         r_lo    <= '0;
`endif
      end else if (flush_i || (w_mem_stall && !w_wb_stall)) begin
         // Bubble: either a squash or MEM stalled while WB advances.
         r_wreg  <= WriteDisable;
         r_waddr <= '0;
         r_wdata <= '0;
`ifdef HILO_WB_EN
         r_whilo <= WriteDisable;
         r_hi    <= '0;
         r_lo    <= '0;
`endif
      end else if (!w_mem_stall) begin
         // Writes to r0 are architecturally dropped.
         r_wreg  <= mem_wreg_i && (mem_waddr_i != '0);
         r_waddr <= mem_waddr_i;
         r_wdata <= mem_wdata_i;
`ifdef HILO_WB_EN
         r_whilo <= mem_whilo_i;
         r_hi    <= mem_hi_i;
         r_lo    <= mem_lo_i;
`endif
      end
   end

   // Results to r0 complete the handshake but are never queued.
   assign w_push = div_valid_i && !w_q_full && (div_waddr_i != '0);

   wb_result_fifo #(
      .DEPTH (QDEPTH),
      .W     (QW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   ({div_waddr_i, div_wdata_i}),
      .i_pop   (w_pop),
      .o_dout  (w_q_head),
      .o_full  (w_q_full),
      .o_empty (w_q_empty),
      .o_count (w_q_count)
   );

   // Pipeline write wins; the queue head fills bubbles unless WB is stalled.
   always_comb begin
      wb_wreg_o  = WriteDisable;
      wb_waddr_o = '0;
      wb_wdata_o = '0;
      w_pop      = 1'b0;
      if (r_wreg) begin
         wb_wreg_o  = WriteEnable;
         wb_waddr_o = r_waddr;
         wb_wdata_o = r_wdata;
      end else if (!w_q_empty && !w_wb_stall) begin
         wb_wreg_o  = WriteEnable;
         {wb_waddr_o, wb_wdata_o} = w_q_head;
         w_pop      = 1'b1;
      end
   end

`ifdef HILO_WB_EN
   assign wb_whilo_o = r_whilo;
   assign wb_hi_o    = r_hi;
   assign wb_lo_o    = r_lo;
`endif

   // Both handshake outputs come only from registered queue state.
   assign div_ready_o = !w_q_full;
   assign stall_req_o = (w_q_count == QFULL_CNT);

endmodule

// File: tb/tb_wb_write_port.sv
module tb_wb_write_port;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic        mem_wreg_i;
   logic [4:0]  mem_waddr_i;
   logic [31:0] mem_wdata_i;
   logic        div_valid_i;
   logic        div_ready_o;
   logic [4:0]  div_waddr_i;
   logic [31:0] div_wdata_i;
   logic        wb_wreg_o;
   logic [4:0]  wb_waddr_o;
   logic [31:0] wb_wdata_o;
   logic        stall_req_o;
`ifdef HILO_WB_EN
   logic        mem_whilo_i;
   logic [31:0] mem_hi_i;
   logic [31:0] mem_lo_i;
   logic        wb_whilo_o;
   logic [31:0] wb_hi_o;
   logic [31:0] wb_lo_o;
`endif

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   wb_write_port #(
      .REG_ADDR_W (5),
      .REG_W      (32),
      .QDEPTH     (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .mem_wreg_i  (mem_wreg_i),
      .mem_waddr_i (mem_waddr_i),
      .mem_wdata_i (mem_wdata_i),
      .div_valid_i (div_valid_i),
      .div_ready_o (div_ready_o),
      .div_waddr_i (div_waddr_i),
      .div_wdata_i (div_wdata_i),
      .wb_wreg_o   (wb_wreg_o),
      .wb_waddr_o  (wb_waddr_o),
      .wb_wdata_o  (wb_wdata_o),
`ifdef HILO_WB_EN
      .mem_whilo_i (mem_whilo_i),
      .mem_hi_i    (mem_hi_i),
      .mem_lo_i    (mem_lo_i),
      .wb_whilo_o  (wb_whilo_o),
      .wb_hi_o     (wb_hi_o),
      .wb_lo_o     (wb_lo_o),
`endif
      .stall_req_o (stall_req_o)
   );

   typedef struct {
      logic        rst;
      logic [5:0]  stall;
      logic        flush;
      logic        mw;
      logic [4:0]  ma;
      logic [31:0] md;
      logic        dv;
      logic [4:0]  da;
      logic [31:0] dd;
      logic        ew;
      logic [4:0]  ea;
      logic [31:0] ed;
      logic        erdy;
      logic        esr;
   } vec_t;

   localparam int NV = 27;
   vec_t vecs [NV];

   function automatic vec_t mk(logic r, logic [5:0] st, logic fl,
                               logic mw, logic [4:0] ma, logic [31:0] md,
                               logic dv, logic [4:0] da, logic [31:0] dd,
                               logic ew, logic [4:0] ea, logic [31:0] ed,
                               logic erdy, logic esr);
      vec_t v;
      v.rst = r;   v.stall = st; v.flush = fl;
      v.mw = mw;   v.ma = ma;    v.md = md;
      v.dv = dv;   v.da = da;    v.dd = dd;
      v.ew = ew;   v.ea = ea;    v.ed = ed;
      v.erdy = erdy; v.esr = esr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      rst = 1'b0; stall_i = 6'd0; flush_i = 1'b0;
      mem_wreg_i = 1'b0; mem_waddr_i = 5'd0; mem_wdata_i = 32'd0;
      div_valid_i = 1'b0; div_waddr_i = 5'd0; div_wdata_i = 32'd0;
`ifdef HILO_WB_EN
      mem_whilo_i = 1'b0; mem_hi_i = 32'd0; mem_lo_i = 32'd0;
`endif
   endtask

   initial begin
      idle_inputs();
      //              rst stall      fl mw ma   md          dv da   dd         ew ea   ed         rdy sr
      vecs[0]  = mk(1, 6'b000000, 0, 0, 0,  32'h0,      0, 0,  32'h0,     0, 0,  32'h0,     1, 0); // reset
      vecs[1]  = mk(0, 6'b000000, 0, 1, 3,  32'h11,     0, 0,  32'h0,     1, 3,  32'h11,    1, 0); // basic write
      vecs[2]  = mk(0, 6'b000000, 0, 1, 0,  32'h22,     0, 0,  32'h0,     0, 0,  32'h0,     1, 0); // r0 write dropped
      vecs[3]  = mk(0, 6'b000000, 0, 0, 0,  32'h0,      1, 0,  32'hFF,    0, 0,  32'h0,     1, 0); // div r0 discarded
      vecs[4]  = mk(0, 6'b000000, 0, 1, 1,  32'h100,    1, 5,  32'hAA,    1, 1,  32'h100,   1, 0); // queue 5/AA
      vecs[5]  = mk(0, 6'b000000, 0, 1, 2,  32'h200,    0, 0,  32'h0,     1, 2,  32'h200,   1, 0); // pipeline wins
      vecs[6]  = mk(0, 6'b000000, 0, 0, 0,  32'h0,      0, 0,  32'h0,     1, 5,  32'hAA,    1, 0); // bubble drains
      vecs[7]  = mk(0, 6'b000000, 0, 0, 0,  32'h0,      0, 0,  32'h0,     0, 0,  32'h0,     1, 0); // queue empty
      vecs[8]  = mk(0, 6'b000000, 0, 1, 4,  32'h400,    1, 6,  32'h66,    1, 4,  32'h400,   1, 0);
      vecs[9]  = mk(0, 6'b000000, 0, 1, 8,  32'h800,    1, 9,  32'h99,    1, 8,  32'h800,   0, 1); // full
      vecs[10] = mk(0, 6'b000000, 0, 1, 10, 32'hA00,    1, 11, 32'hBB,    1, 10, 32'hA00,   0, 1); // push refused
      vecs[11] = mk(0, 6'b011111, 0, 1, 12, 32'hC00,    0, 0,  32'h0,     1, 6,  32'h66,    0, 1); // bubble in WB
      vecs[12] = mk(0, 6'b000000, 0, 0, 0,  32'h0,      0, 0,  32'h0,     1, 9,  32'h99,    1, 0); // popped, req drops
      vecs[13] = mk(0, 6'b000000, 0, 0, 0,  32'h0,      0, 0,  32'h0,     0, 0,  32'h0,     1, 0);
      vecs[14] = mk(0, 6'b000000, 0, 1, 13, 32'hD00,    1, 7,  32'h55,    1, 13, 32'hD00,   1, 0);
      vecs[15] = mk(0, 6'b000000, 1, 1, 14, 32'hE00,    0, 0,  32'h0,     1, 7,  32'h55,    1, 0); // flush keeps queue
      vecs[16] = mk(0, 6'b000000, 0, 0, 0,  32'h0,      0, 0,  32'h0,     0, 0,  32'h0,     1, 0);
      vecs[17] = mk(0, 6'b000000, 0, 1, 15, 32'hF00,    0, 0,  32'h0,     1, 15, 32'hF00,   1, 0);
      vecs[18] = mk(0, 6'b110000, 0, 1, 16, 32'h1000,   0, 0,  32'h0,     1, 15, 32'hF00,   1, 0); // hold
      vecs[19] = mk(0, 6'b100000, 0, 0, 0,  32'h0,      1, 17, 32'h1700,  0, 0,  32'h0,     1, 0); // WB stall blocks drain
      vecs[20] = mk(0, 6'b100000, 0, 0, 0,  32'h0,      1, 18, 32'h1800,  0, 0,  32'h0,     0, 1);
      vecs[21] = mk(0, 6'b000000, 0, 0, 0,  32'h0,      0, 0,  32'h0,     1, 18, 32'h1800,  1, 0); // FIFO order
      vecs[22] = mk(0, 6'b000000, 0, 0, 0,  32'h0,      1, 19, 32'h1900,  1, 19, 32'h1900,  1, 0); // push+pop
      vecs[23] = mk(0, 6'b000000, 0, 0, 0,  32'h0,      0, 0,  32'h0,     0, 0,  32'h0,     1, 0);
      vecs[24] = mk(0, 6'b100000, 0, 0, 0,  32'h0,      1, 20, 32'h2000,  0, 0,  32'h0,     1, 0);
      vecs[25] = mk(1, 6'b100000, 0, 0, 0,  32'h0,      0, 0,  32'h0,     0, 0,  32'h0,     1, 0); // reset mid-drain
      vecs[26] = mk(0, 6'b000000, 0, 0, 0,  32'h0,      0, 0,  32'h0,     0, 0,  32'h0,     1, 0); // nothing left

      for (int i = 0; i < NV; i++) begin
         rst         = vecs[i].rst;
         stall_i     = vecs[i].stall;
         flush_i     = vecs[i].flush;
         mem_wreg_i  = vecs[i].mw;
         mem_waddr_i = vecs[i].ma;
         mem_wdata_i = vecs[i].md;
         div_valid_i = vecs[i].dv;
         div_waddr_i = vecs[i].da;
         div_wdata_i = vecs[i].dd;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d wreg", i),  {31'd0, wb_wreg_o},   {31'd0, vecs[i].ew});
         chk($sformatf("v%0d waddr", i), {27'd0, wb_waddr_o},  {27'd0, vecs[i].ea});
         chk($sformatf("v%0d wdata", i), wb_wdata_o,           vecs[i].ed);
         chk($sformatf("v%0d ready", i), {31'd0, div_ready_o}, {31'd0, vecs[i].erdy});
         chk($sformatf("v%0d streq", i), {31'd0, stall_req_o}, {31'd0, vecs[i].esr});
      end

      // Queued head appears combinationally as soon as the WB stall lifts.
      idle_inputs();
      stall_i = 6'b100000;
      div_valid_i = 1'b1; div_waddr_i = 5'd21; div_wdata_i = 32'h2100;
      @(posedge clk);
      #1;
      div_valid_i = 1'b0;
      #1;
      chk("wbstall hidden", {31'd0, wb_wreg_o}, 32'd0);
      stall_i = 6'b000000;
      #1;
      chk("unstall wreg",  {31'd0, wb_wreg_o}, 32'd1);
      chk("unstall waddr", {27'd0, wb_waddr_o}, 32'd21);
      chk("unstall wdata", wb_wdata_o, 32'h2100);
      @(posedge clk);
      #1;
      chk("after pop wreg", {31'd0, wb_wreg_o}, 32'd0);

`ifdef HILO_WB_EN
      idle_inputs();
      mem_whilo_i = 1'b1; mem_hi_i = 32'h1; mem_lo_i = 32'h2;
      @(posedge clk);
      #1;
      chk("hilo we", {31'd0, wb_whilo_o}, 32'd1);
      chk("hilo hi", wb_hi_o, 32'h1);
      chk("hilo lo", wb_lo_o, 32'h2);
      stall_i = 6'b010000;
      @(posedge clk);
      #1;
      chk("hilo bubble", {31'd0, wb_whilo_o}, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
